// File: rtl/sw_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debounce_pkg
//  Description : Shared constants for the switch debouncer and the board top,
//                plus the counter-width helper used by each debounce lane.
//  Revision    : 1.0 - initial release
// ============================================================================
package sw_debounce_pkg;

    // Board-level defaults: number of switch lines and debounce interval
    localparam int c_DEF_WIDTH     = 8;
    localparam int c_DEF_DB_CYCLES = 10000;

    // Counter width: ceil(log2(db)), never less than one bit
    function automatic int cnt_width(input int db);
        return (db <= 1) ? 1 : $clog2(db);
    endfunction

endpackage : sw_debounce_pkg
`default_nettype wire

// File: rtl/sw_debounce_db_bit.sv
`default_nettype none
// ============================================================================
//  Module      : db_bit
//  Description : One debounce lane: 2-flop synchronizer, saturating mismatch
//                counter, stable flop and registered rise/fall pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module db_bit
    import sw_debounce_pkg::*;
#(
    parameter int DB_CYCLES = c_DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o,
    output logic accept_o
);

    localparam int            CW        = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] c_CNT_MAX = CW'(DB_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic          stable_q;
    logic          stable_d;
    logic          rise_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          accept_w;

    // Bring the raw switch level into the clk domain before anything uses it
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= sw_i;
            s2_q <= s1_q;
        end
    end

    // Count consecutive mismatches; accept the new level once the count tops out
    always_comb begin
        accept_w = 1'b0;
        cnt_d    = '0;
        stable_d = stable_q;
        if (s2_q != stable_q) begin
            if (cnt_q == c_CNT_MAX) begin
                accept_w = 1'b1;
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter, stable level and edge pulses all update together
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= accept_w & s2_q;
            fall_q   <= accept_w & ~s2_q;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign accept_o = accept_w;

endmodule : db_bit
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debounce
//  Description : WIDTH independent debounce lanes with a shared change pulse
//                and an any-switch-on indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH     = c_DEF_WIDTH,
    parameter int DB_CYCLES = c_DEF_DB_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic             any_on
);

    logic [WIDTH-1:0] accept_w;
    logic             changed_q;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bits
            db_bit #(
                .DB_CYCLES (DB_CYCLES)
            ) u_bit (
                .clk      (clk),
                .rst      (rst),
                .sw_i     (sw[i]),
                .stable_o (sw_stable[i]),
                .rise_o   (rise[i]),
                .fall_o   (fall[i]),
                .accept_o (accept_w[i])
            );
        end
    endgenerate

    // Registered alongside the lane pulses so changed lines up with rise/fall
    always_ff @(posedge clk) begin
        if (rst) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |accept_w;
        end
    end

    assign changed = changed_q;
    assign any_on  = |sw_stable;

endmodule : sw_debounce
`default_nettype wire

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 8: number of switch lines handled.
REQ-002 Parameter DB_CYCLES, default 10000: consecutive mismatch cycles required before a switch change is accepted; legal range 1..65535.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 sw  input  WIDTH  raw asynchronous switch levels.
REQ-006 sw_stable  output  WIDTH  debounced switch levels; feeds the enable/priority-encoder path.
REQ-007 rise  output  WIDTH  one-cycle pulse per bit when sw_stable[i] changes 0->1.
REQ-008 fall  output  WIDTH  one-cycle pulse per bit when sw_stable[i] changes 1->0.
REQ-009 changed  output  1  one-cycle pulse, equal to OR of rise and fall.
REQ-010 any_on  output  1  equal to OR-reduction of sw_stable.

Function
REQ-011 Each bit SHALL pass through a 2-flop synchronizer (s1, s2) before any other use; sw SHALL NOT reach any other logic directly.
REQ-012 Each bit SHALL own a counter of ceil(log2(DB_CYCLES)) bits (minimum 1), unsigned, never wrapping.
REQ-013 When s2[i] equals sw_stable[i], cnt[i] SHALL be cleared to 0 on the next edge.
REQ-014 When s2[i] differs from sw_stable[i] and cnt[i] < DB_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-015 When s2[i] differs from sw_stable[i] and cnt[i] == DB_CYCLES-1, sw_stable[i] SHALL take s2[i] and cnt[i] SHALL clear on the same edge.
REQ-016 Latency: a level held on sw[i] SHALL appear on sw_stable[i] at the (DB_CYCLES+2)-th rising edge that samples the new level, counting the first sampling edge as 1.
REQ-017 A glitch whose synchronized level reverts before REQ-015 fires SHALL leave sw_stable[i] unchanged and produce no pulse; the next mismatch SHALL restart counting from 0.
REQ-018 rise/fall/changed SHALL be registered, asserted in the cycle immediately after the sw_stable update edge, for exactly one cycle per accepted change.
REQ-019 Bits SHALL be fully independent; simultaneous acceptance on several bits SHALL assert each corresponding rise/fall bit in the same cycle, with a single-cycle changed pulse.
REQ-020 any_on SHALL be combinational from sw_stable (no added latency).

Reset
REQ-021 While rst is high at a rising edge: s1, s2, cnt, sw_stable, rise, fall, changed SHALL all become 0; any_on therefore 0.
REQ-022 Reset asserted mid-count SHALL discard the partial count; after release, a held-high switch SHALL be accepted as a fresh 0->1 change per REQ-016 and SHALL produce a rise pulse.
REQ-023 No output SHALL pulse during, or in the cycle following, a reset edge.

Structure
REQ-024 Defaults for WIDTH and DB_CYCLES SHALL live in the shared constants package/header used by the board-level top, not be hard-coded in sw_debounce.
REQ-025 One sub-module, db_bit (synchronizer, counter, stable flop, rise/fall pulse for one line), SHALL be instantiated WIDTH times by a generate loop; sw_debounce adds only the changed/any_on reduction.
REQ-026 The design SHALL contain no latches, no clock gating, and no asynchronous reset paths.

Verification (DB_CYCLES overridden to 4)
REQ-027 Reset, then sw=8'h00 for 20 cycles -> sw_stable=8'h00; rise, fall, changed, any_on constantly 0.
REQ-028 sw=8'h01 held from edge 1 -> sw_stable=8'h01 at edge 6; rise=8'h01 and changed=1 for exactly the following cycle; any_on=1 from edge 6.
REQ-029 sw[3] pulsed high for 3 edges then low -> sw_stable unchanged, no rise/fall/changed pulse; counter observed back at 0.
REQ-030 sw 8'h00->8'h81 on one edge, later 8'h81->8'h80 -> rise=8'h81 in one cycle with a single changed pulse; later fall=8'h01 only.
REQ-031 sw=8'hFF held, rst asserted for 1 cycle after 3 accepting-path edges -> all outputs 0 next cycle; sw_stable=8'hFF 6 edges after release with rise=8'hFF.
REQ-032 Random sw toggling at intervals 1..10 cycles for 10000 cycles vs. reference model -> sw_stable, rise, fall match cycle-exactly.
